// File: rtl/llc_pkg.sv
// Shared LLC types and constants used by the lookup stage and its helpers.
package llc_pkg;

    localparam int unsigned NUM_WAYS      = 16;
    localparam int unsigned WAY_BITS      = 4;
    localparam int unsigned LLC_SET_BITS  = 10;
    localparam int unsigned LLC_TAG_BITS  = 16;
    localparam int unsigned STATE_BITS    = 3;
    localparam int unsigned LLC_ADDR_BITS = LLC_TAG_BITS + LLC_SET_BITS;

    typedef logic [LLC_SET_BITS-1:0] llc_set_t;
    typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;
    typedef logic [WAY_BITS-1:0]     llc_way_t;
    typedef logic [STATE_BITS-1:0]   llc_state_t;

    localparam llc_state_t LLC_STATE_INVALID = '0;

    typedef enum logic [1:0] {
        LK_IDLE,
        LK_READ,
        LK_CAPTURE,
        LK_RESP
    } lookup_state_e;

endpackage

// File: rtl/llc_way_search.sv
// Circular priority search: first set bit of i_match at or after i_start,
// wrapping from N-1 back to 0.
module llc_way_search #(
    parameter int unsigned N  = 16,
    parameter int unsigned WB = 4
) (
    input  logic [N-1:0]  i_match,
    input  logic [WB-1:0] i_start,
    output logic          o_found_c,
    output logic [WB-1:0] o_way_c
);

    always_comb begin
        o_found_c = 1'b0;
        o_way_c   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_found_c && i_match[WB'(i_start + WB'(i))]) begin
                o_found_c = 1'b1;
                o_way_c   = WB'(i_start + WB'(i));
            end
        end
    end

endmodule

// File: rtl/llc_lookup.sv
// LLC lookup stage: reads one set, compares tags, picks hit/empty/victim way
// and returns the result over a valid/ready response.
module llc_lookup
    import llc_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [LLC_ADDR_BITS-1:0]         req_line_addr,
    output logic                             mem_rd_en,
    output logic [LLC_SET_BITS-1:0]          mem_rd_set,
    input  logic [NUM_WAYS*LLC_TAG_BITS-1:0] mem_rd_tag,
    input  logic [NUM_WAYS*STATE_BITS-1:0]   mem_rd_state,
    input  logic [WAY_BITS-1:0]              mem_rd_evict_way,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic                             rsp_hit,
    output logic [WAY_BITS-1:0]              rsp_way,
    output logic                             rsp_empty,
    output logic [STATE_BITS-1:0]            rsp_state,
    output logic [LLC_SET_BITS-1:0]          rsp_set,
    output logic [LLC_TAG_BITS-1:0]          rsp_tag,
    output logic [WAY_BITS-1:0]              rsp_evict_way_next
);

    lookup_state_e r_state;
    lookup_state_e w_state_next;

    llc_tag_t   r_tag;
    llc_set_t   r_set;
    logic       r_req_ready;
    logic       r_mem_rd_en;
    logic       r_rsp_valid;
    logic       r_rsp_hit;
    llc_way_t   r_rsp_way;
    logic       r_rsp_empty;
    llc_state_t r_rsp_state;
    llc_way_t   r_rsp_evict_next;

    logic                w_accept;
    logic [NUM_WAYS-1:0] w_hit_vec;
    logic [NUM_WAYS-1:0] w_inv_vec;
    logic                w_hit;
    llc_way_t            w_hit_way;
    logic                w_inv;
    llc_way_t            w_inv_way;
    llc_way_t            w_sel_way;
    llc_state_t          w_sel_state;
    llc_way_t            w_evict_next;

    assign w_accept = req_valid & r_req_ready;

    // Per-way match vectors from the captured set read
    always_comb begin
        w_hit_vec = '0;
        w_inv_vec = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            w_inv_vec[w] = (mem_rd_state[w*STATE_BITS +: STATE_BITS] == LLC_STATE_INVALID);
            w_hit_vec[w] = !w_inv_vec[w] &&
                           (mem_rd_tag[w*LLC_TAG_BITS +: LLC_TAG_BITS] == r_tag);
        end
    end

    llc_way_search #(.N(NUM_WAYS), .WB(WAY_BITS)) u_hit_search (
        .i_match   (w_hit_vec),
        .i_start   (WAY_BITS'(0)),
        .o_found_c (w_hit),
        .o_way_c   (w_hit_way)
    );

    llc_way_search #(.N(NUM_WAYS), .WB(WAY_BITS)) u_inv_search (
        .i_match   (w_inv_vec),
        .i_start   (mem_rd_evict_way),
        .o_found_c (w_inv),
        .o_way_c   (w_inv_way)
    );

    // Hit way wins, then first empty way from the pointer, then the pointer itself
    always_comb begin
        w_sel_way    = mem_rd_evict_way;
        w_evict_next = mem_rd_evict_way;
        if (w_hit) begin
            w_sel_way = w_hit_way;
        end else begin
            if (w_inv) begin
                w_sel_way = w_inv_way;
            end
            w_evict_next = WAY_BITS'(w_sel_way + WAY_BITS'(1));
        end
        w_sel_state = mem_rd_state[w_sel_way*STATE_BITS +: STATE_BITS];
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            LK_IDLE:    if (w_accept) w_state_next = LK_READ;
            LK_READ:    w_state_next = LK_CAPTURE;
            LK_CAPTURE: w_state_next = LK_RESP;
            LK_RESP:    if (rsp_ready) w_state_next = LK_IDLE;
            default:    w_state_next = LK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= LK_IDLE;
            r_req_ready      <= 1'b1;
            r_mem_rd_en      <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_tag            <= '0;
            r_set            <= '0;
            r_rsp_hit        <= 1'b0;
            r_rsp_way        <= '0;
            r_rsp_empty      <= 1'b0;
            r_rsp_state      <= '0;
            r_rsp_evict_next <= '0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == LK_IDLE);
            r_mem_rd_en <= (w_state_next == LK_READ);
            r_rsp_valid <= (w_state_next == LK_RESP);
            if (w_accept) begin
                r_tag <= req_line_addr[LLC_ADDR_BITS-1 -: LLC_TAG_BITS];
                r_set <= req_line_addr[LLC_SET_BITS-1:0];
            end
            if (r_state == LK_CAPTURE) begin
                r_rsp_hit        <= w_hit;
                r_rsp_way        <= w_sel_way;
                r_rsp_empty      <= !w_hit && w_inv;
                r_rsp_state      <= w_sel_state;
                r_rsp_evict_next <= w_evict_next;
            end
        end
    end

    assign req_ready          = r_req_ready;
    assign mem_rd_en          = r_mem_rd_en;
    assign mem_rd_set         = r_set;
    assign rsp_valid          = r_rsp_valid;
    assign rsp_hit            = r_rsp_hit;
    assign rsp_way            = r_rsp_way;
    assign rsp_empty          = r_rsp_empty;
    assign rsp_state          = r_rsp_state;
    assign rsp_set            = r_set;
    assign rsp_tag            = r_tag;
    assign rsp_evict_way_next = r_rsp_evict_next;

endmodule

// File: tb/tb_llc_lookup.sv
// Directed bench for llc_lookup with a one-cycle-latency set memory model.
module tb_llc_lookup;
    import llc_pkg::*;

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             req_valid;
    logic                             req_ready;
    logic [LLC_ADDR_BITS-1:0]         req_line_addr;
    logic                             mem_rd_en;
    logic [LLC_SET_BITS-1:0]          mem_rd_set;
    logic [NUM_WAYS*LLC_TAG_BITS-1:0] mem_rd_tag;
    logic [NUM_WAYS*STATE_BITS-1:0]   mem_rd_state;
    logic [WAY_BITS-1:0]              mem_rd_evict_way;
    logic                             rsp_valid;
    logic                             rsp_ready;
    logic                             rsp_hit;
    logic [WAY_BITS-1:0]              rsp_way;
    logic                             rsp_empty;
    logic [STATE_BITS-1:0]            rsp_state;
    logic [LLC_SET_BITS-1:0]          rsp_set;
    logic [LLC_TAG_BITS-1:0]          rsp_tag;
    logic [WAY_BITS-1:0]              rsp_evict_way_next;

    llc_tag_t   m_tag   [NUM_WAYS];
    llc_state_t m_state [NUM_WAYS];
    llc_way_t   m_evict;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    llc_lookup dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_line_addr      (req_line_addr),
        .mem_rd_en          (mem_rd_en),
        .mem_rd_set         (mem_rd_set),
        .mem_rd_tag         (mem_rd_tag),
        .mem_rd_state       (mem_rd_state),
        .mem_rd_evict_way   (mem_rd_evict_way),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_hit            (rsp_hit),
        .rsp_way            (rsp_way),
        .rsp_empty          (rsp_empty),
        .rsp_state          (rsp_state),
        .rsp_set            (rsp_set),
        .rsp_tag            (rsp_tag),
        .rsp_evict_way_next (rsp_evict_way_next)
    );

    // Set memory: data valid only in the cycle after mem_rd_en, junk otherwise
    always @(posedge clk) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            mem_rd_tag[w*LLC_TAG_BITS +: LLC_TAG_BITS] <= mem_rd_en ? m_tag[w] : 16'hFFFF;
            mem_rd_state[w*STATE_BITS +: STATE_BITS]   <= mem_rd_en ? m_state[w] : 3'd7;
        end
        mem_rd_evict_way <= mem_rd_en ? m_evict : 4'd10;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fill_set(input logic [15:0] base, input logic [2:0] st, input logic [3:0] ev);
        for (int w = 0; w < NUM_WAYS; w++) begin
            m_tag[w]   = base + 16'(w);
            m_state[w] = st;
        end
        m_evict = ev;
    endtask

    // Drive one request from IDLE; returns in the READ cycle
    task automatic issue(input logic [15:0] tag, input logic [9:0] set);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_line_addr = {tag, set};
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_en_T1", 32'(mem_rd_en), 32'd1);
        check("rd_set_T1", 32'(mem_rd_set), 32'(set));
        check("req_ready_busy", 32'(req_ready), 32'd0);
    endtask

    task automatic wait_rsp();
        @(negedge clk);
        check("rd_en_T2", 32'(mem_rd_en), 32'd0);
        check("rsp_valid_T2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rsp_valid_T3", 32'(rsp_valid), 32'd1);
    endtask

    task automatic check_rsp(input logic hit, input logic [3:0] way, input logic empty,
                             input logic [2:0] st, input logic [3:0] evn,
                             input logic [9:0] set, input logic [15:0] tag);
        check("rsp_hit", 32'(rsp_hit), 32'(hit));
        check("rsp_way", 32'(rsp_way), 32'(way));
        check("rsp_empty", 32'(rsp_empty), 32'(empty));
        check("rsp_state", 32'(rsp_state), 32'(st));
        check("rsp_evict_next", 32'(rsp_evict_way_next), 32'(evn));
        check("rsp_set", 32'(rsp_set), 32'(set));
        check("rsp_tag", 32'(rsp_tag), 32'(tag));
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_line_addr = '0;
        rsp_ready     = 1'b0;
        fill_set(16'h0000, 3'd0, 4'd0);
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_way", 32'(rsp_way), 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        rst = 1'b0;

        // Hit in way 3
        fill_set(16'h1000, 3'd1, 4'd7);
        m_tag[3] = 16'h1234; m_state[3] = 3'd2;
        issue(16'h1234, 10'd5);
        wait_rsp();
        check_rsp(1'b1, 4'd3, 1'b0, 3'd2, 4'd7, 10'd5, 16'h1234);
        handshake();

        // Empty search wraps from 14 to way 1
        fill_set(16'h2000, 3'd1, 4'd14);
        m_state[1] = 3'd0;
        issue(16'h0ABC, 10'h3FF);
        wait_rsp();
        check_rsp(1'b0, 4'd1, 1'b1, 3'd0, 4'd2, 10'h3FF, 16'h0ABC);
        handshake();

        // Full miss with pointer 15: next pointer wraps to 0
        fill_set(16'h3000, 3'd1, 4'd15);
        m_state[15] = 3'd3;
        issue(16'h0777, 10'd0);
        wait_rsp();
        check_rsp(1'b0, 4'd15, 1'b0, 3'd3, 4'd0, 10'd0, 16'h0777);
        handshake();

        // Duplicate hit: lowest way wins, hit beats an empty way
        fill_set(16'h4000, 3'd1, 4'd5);
        m_tag[2] = 16'h4444; m_state[2] = 3'd1;
        m_tag[9] = 16'h4444; m_state[9] = 3'd4;
        m_state[6] = 3'd0;
        issue(16'h4444, 10'd77);
        wait_rsp();
        check_rsp(1'b1, 4'd2, 1'b0, 3'd1, 4'd5, 10'd77, 16'h4444);
        handshake();

        // Non-wrapping empty search: first invalid way at or after pointer 0
        fill_set(16'h5000, 3'd2, 4'd0);
        m_state[5] = 3'd0; m_state[10] = 3'd0;
        issue(16'h5555, 10'd300);
        wait_rsp();
        check_rsp(1'b0, 4'd5, 1'b1, 3'd0, 4'd6, 10'd300, 16'h5555);
        handshake();

        // Backpressure with a competing request held on req_valid
        fill_set(16'h6000, 3'd1, 4'd0);
        m_tag[12] = 16'h0C0C; m_state[12] = 3'd5;
        issue(16'h0C0C, 10'd12);
        wait_rsp();
        req_valid     = 1'b1;
        req_line_addr = {16'h9999, 10'd99};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rd_en", 32'(mem_rd_en), 32'd0);
            check("bp_rsp_way", 32'(rsp_way), 32'd12);
            check("bp_rsp_tag", 32'(rsp_tag), 32'h0C0C);
        end
        req_valid = 1'b0;
        check_rsp(1'b1, 4'd12, 1'b0, 3'd5, 4'd0, 10'd12, 16'h0C0C);
        handshake();
        fill_set(16'h7000, 3'd1, 4'd3);
        issue(16'h7003, 10'd400);
        wait_rsp();
        check_rsp(1'b1, 4'd3, 1'b0, 3'd1, 4'd3, 10'd400, 16'h7003);
        handshake();

        // Reset during READ: no response afterwards
        issue(16'h7004, 10'd401);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("post_rst_req_ready", 32'(req_ready), 32'd1);
        end

        // Still operational after reset
        issue(16'h7005, 10'd402);
        wait_rsp();
        check_rsp(1'b1, 4'd5, 1'b0, 3'd1, 4'd3, 10'd402, 16'h7005);
        handshake();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
